// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// N-channel switch/button debouncer. Each channel has a 2-FF synchroniser with
// polarity correction, a stability counter, a clean debounced level and
// one-cycle rise/fall event pulses. A registered OR of all debounced levels is
// also provided.
//
// Optional feature (compile-time macro DEBOUNCE_LONG_PRESS_EN):
//   When defined, each channel gets a hold counter. long_press[i] pulses once
//   per press, LONG_CNT cycles after the debounced level went high. When the
//   macro is undefined, no hold counters exist and long_press is tied to 0.
//
// Ports:
//   clk         in   1     system clock
//   reset_n     in   1     asynchronous active-low reset
//   sw_in       in   N_CH  raw asynchronous switch pins
//   sw_state    out  N_CH  debounced level, 1 = pressed
//   sw_rise     out  N_CH  1-cycle pulse when sw_state[i] goes 0->1
//   sw_fall     out  N_CH  1-cycle pulse when sw_state[i] goes 1->0
//   any_active  out  1     registered OR of sw_state
//   long_press  out  N_CH  1-cycle pulse at the long-press threshold
// -----------------------------------------------------------------------------
module debounce_multi #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 10,
  parameter int STABLE_CNT = 200,
  parameter int ACTIVE_LOW = 1,
  parameter int LONG_W     = 16,
  parameter int LONG_CNT   = 5000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_state,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic            any_active,
  output logic [N_CH-1:0] long_press
);

  // Elaboration-time parameter sanity checks.
  if (N_CH < 1) begin : g_bad_nch
    $error("debounce_multi: N_CH must be >= 1");
  end
  if (STABLE_CNT < 1 || STABLE_CNT >= (2 ** CNT_W)) begin : g_bad_stable
    $error("debounce_multi: STABLE_CNT must satisfy 1 <= STABLE_CNT < 2**CNT_W");
  end
  if (LONG_CNT < 1 || LONG_CNT >= (2 ** LONG_W)) begin : g_bad_long
    $error("debounce_multi: LONG_CNT must satisfy 1 <= LONG_CNT < 2**LONG_W");
  end

  localparam logic             POL         = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

  logic [N_CH-1:0] r_s0;
  logic [N_CH-1:0] r_s1;
  logic [N_CH-1:0] r_state;
  logic [N_CH-1:0] r_rise;
  logic [N_CH-1:0] r_fall;
  logic            r_any;
  logic [N_CH-1:0] w_state_next;

  // Synchroniser. Polarity is folded into the first stage so that the reset
  // value 0 always means "released".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0 <= '0;
      r_s1 <= '0;
    end else begin
      r_s0 <= sw_in ^ {N_CH{POL}};
      r_s1 <= r_s0;
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CNT);
  logic [N_CH-1:0] w_long_hit;
  logic [N_CH-1:0] r_long;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic             w_diff;
      logic             w_toggle;

      assign w_diff   = r_s1[gi] ^ r_state[gi];
      // Toggle on the STABLE_CNT-th consecutive mismatching cycle; the counter
      // is cleared at the same time, so it never exceeds STABLE_CNT-1.
      assign w_toggle = w_diff && (r_cnt == STABLE_LAST);
      assign w_state_next[gi] = r_state[gi] ^ w_toggle;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (!w_diff || w_toggle) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

`ifdef DEBOUNCE_LONG_PRESS_EN
      logic [LONG_W-1:0] r_hold;

      // Pulse when the hold count crosses LONG_CNT-1 -> LONG_CNT; the count
      // then saturates so the pulse cannot repeat until the channel releases.
      assign w_long_hit[gi] = r_state[gi] && (r_hold == LONG_LAST);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_hold <= '0;
        end else if (!r_state[gi]) begin
          r_hold <= '0;
        end else if (r_hold != LONG_MAX) begin
          r_hold <= r_hold + LONG_W'(1);
        end
      end
`endif
    end
  endgenerate

  // Debounced level, edge pulses and OR-reduction all derive from the
  // next-state vector so they change in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_any   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rise  <= w_state_next & ~r_state;
      r_fall  <= ~w_state_next & r_state;
      r_any   <= |w_state_next;
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_long <= '0;
    end else begin
      r_long <= w_long_hit;
    end
  end
  assign long_press = r_long;
`else
  assign long_press = '0;
`endif

  assign sw_state   = r_state;
  assign sw_rise    = r_rise;
  assign sw_fall    = r_fall;
  assign any_active = r_any;

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//
// Directed bench for debounce_multi (N_CH=4, STABLE_CNT=8, ACTIVE_LOW=1,
// LONG_CNT=32). A behavioural model derives the expected outputs from a
// sliding window of synchronised samples; a compare process checks every
// cycle, and directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

  localparam int N_CH   = 4;
  localparam int STABLE = 8;
  localparam int LONG   = 32;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] sw_in;
  logic [3:0] sw_state, sw_rise, sw_fall, long_press;
  logic       any_active;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_CH(N_CH), .CNT_W(10), .STABLE_CNT(STABLE), .ACTIVE_LOW(1),
    .LONG_W(16), .LONG_CNT(LONG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_in(sw_in),
    .sw_state(sw_state), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .any_active(any_active), .long_press(long_press)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A channel's level flips once its last STABLE synchronised samples all
  // disagree with the current level. Long press: exactly LONG cycles after the
  // rise, provided the level has stayed high.
  logic [3:0] m_p0 = '0, m_p1 = '0, m_state = '0, m_rise = '0, m_fall = '0, m_long = '0, m_ns;
  logic       m_any = 1'b0;
  logic [STABLE-1:0] m_hist [4];
  logic [STABLE-1:0] m_win;
  int m_cyc = 0;
  int m_rise_cyc [4];

  initial for (int c = 0; c < 4; c++) begin m_hist[c] = '0; m_rise_cyc[c] = -100000; end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_p0 = '0; m_p1 = '0; m_state = '0; m_rise = '0; m_fall = '0;
      m_long = '0; m_any = 1'b0;
      for (int c = 0; c < 4; c++) begin m_hist[c] = '0; m_rise_cyc[c] = -100000; end
    end else begin
      m_cyc++;
      for (int c = 0; c < 4; c++) begin
        m_win = {m_hist[c][STABLE-2:0], m_p1[c]};
        m_hist[c] = m_win;
        m_ns[c] = (m_win == {STABLE{~m_state[c]}}) ? ~m_state[c] : m_state[c];
        m_long[c] = m_state[c] && ((m_cyc - m_rise_cyc[c]) == LONG);
        if (m_ns[c] && !m_state[c]) m_rise_cyc[c] = m_cyc;
      end
      m_rise  = m_ns & ~m_state;
      m_fall  = ~m_ns & m_state;
      m_any   = |m_ns;
      m_state = m_ns;
      m_p1    = m_p0;
      m_p0    = ~sw_in;
    end
  end

  logic [3:0] exp_long;
`ifdef DEBOUNCE_LONG_PRESS_EN
  assign exp_long = m_long;
  localparam logic LP_ON = 1'b1;
`else
  assign exp_long = '0;
  localparam logic LP_ON = 1'b0;
`endif

  // ---------------- per-cycle compare ----------------
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_state", sw_state, m_state);
      check("cyc_rise",  sw_rise,  m_rise);
      check("cyc_fall",  sw_fall,  m_fall);
      check("cyc_any",   {3'b0, any_active}, {3'b0, m_any});
      check("cyc_long",  long_press, exp_long);
    end
  end

  // ---------------- event monitors ----------------
  int lp_cnt = 0;   // long_press[0] pulses
  int ev1    = 0;   // any activity on channel 1
  int fc0    = 0;   // sw_fall[0] pulses
  always @(posedge clk) begin
    #1;
    if (long_press[0]) lp_cnt++;
    if (sw_state[1] || sw_rise[1] || sw_fall[1]) ev1++;
    if (sw_fall[0]) fc0++;
  end

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    sw_in   = 4'hF;             // all released (active low)
    steps(3);
    check("rst_state", sw_state, 4'b0000);
    check("rst_rise",  sw_rise,  4'b0000);
    check("rst_fall",  sw_fall,  4'b0000);
    check("rst_any",   {3'b0, any_active}, 4'b0000);
    check("rst_long",  long_press, 4'b0000);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    steps(4);

    // 1: press ch0, rise exactly 10 cycles after the pin edge
    lp_cnt = 0;
    sw_in[0] = 1'b0;
    steps(9);
    check("t1_rise_early", sw_rise, 4'b0000);
    steps(1);
    check("t1_rise",  sw_rise,  4'b0001);
    check("t1_state", sw_state, 4'b0001);
    check("t1_any",   {3'b0, any_active}, 4'b0001);
    steps(1);
    check("t1_rise_gone", sw_rise, 4'b0000);

    // 6: long press 32 cycles after the rise, exactly once while held
    steps(30);
    check("t6_long_early", long_press, 4'b0000);
    steps(1);
    check("t6_long", long_press, {3'b0, LP_ON});
    steps(60);
    check("t6_long_once", 4'(lp_cnt), {3'b0, LP_ON});

    // 3: release ch0
    sw_in[0] = 1'b1;
    steps(9);
    check("t3_fall_early", sw_fall, 4'b0000);
    steps(1);
    check("t3_fall",  sw_fall,  4'b0001);
    check("t3_state", sw_state, 4'b0000);
    check("t3_any",   {3'b0, any_active}, 4'b0000);
    steps(3);

    // 2: bounce ch1 every 3 cycles for 40 cycles
    ev1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sw_in[1] = ~sw_in[1];
      steps(1);
    end
    sw_in[1] = 1'b1;
    steps(15);
    check("t2_bounce_events", 4'(ev1), 4'd0);

    // 4: ch2 and ch3 pressed together
    sw_in[3:2] = 2'b00;
    steps(10);
    check("t4_rise", sw_rise, 4'b1100);
    check("t4_any",  {3'b0, any_active}, 4'b0001);
    sw_in[3:2] = 2'b11;
    steps(12);
    check("t4_released", sw_state, 4'b0000);

    // 6b: release then re-press re-arms the long press
    lp_cnt = 0;
    sw_in[0] = 1'b0;
    steps(10);
    check("t6b_rise", sw_rise, 4'b0001);
    steps(32);
    check("t6b_long", long_press, {3'b0, LP_ON});
    sw_in[0] = 1'b1;
    steps(14);
    check("t6b_count", 4'(lp_cnt), {3'b0, LP_ON});

    // 5: reset in the middle of a count
    fc0 = 0;
    sw_in[0] = 1'b0;
    steps(5);
    reset_n = 1'b0;
    #1;
    check("t5_rst_state", sw_state, 4'b0000);
    check("t5_rst_any",   {3'b0, any_active}, 4'b0000);
    steps(3);
    check("t5_rst_hold",  sw_rise | sw_fall, 4'b0000);
    reset_n = 1'b1;
    steps(9);
    check("t5_rise_early", sw_state, 4'b0000);
    steps(1);
    check("t5_rise", sw_rise, 4'b0001);
    steps(3);
    check("t5_no_fall", 4'(fc0), 4'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
